// File: rtl/ps2_pkg.sv
// ps2_pkg
//   Shared definitions for the PS/2 receive path and the downstream
//   keyboard scan-code FSM: frame FSM state encoding, frame geometry,
//   the scan codes the keyboard FSM decodes, and an odd-parity helper.
package ps2_pkg;

  localparam int FRAME_DATA_BITS = 8;

  localparam logic [7:0] SC_EXTENDED = 8'hE0;
  localparam logic [7:0] SC_RELEASE  = 8'hF0;
  localparam logic [7:0] SC_UP       = 8'h75;
  localparam logic [7:0] SC_RIGHT    = 8'h74;
  localparam logic [7:0] SC_LEFT     = 8'h6B;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_t;

  // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [FRAME_DATA_BITS-1:0] data,
                                         input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter
//   2-FF synchroniser followed by a run-length glitch filter. The filtered
//   output only changes level once FILTER_LEN consecutive synchronised
//   samples disagree with it, so it lags the pad by 2 + FILTER_LEN cycles.
// Ports:
//   clk      in   system clock
//   resetn   in   asynchronous active-low reset
//   raw      in   asynchronous pad signal
//   filtered out  synchronised, glitch-filtered level (registered, resets to 1)
module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw,
  output logic filtered
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] run_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the synchroniser and filter reset to 1 (the idle PS/2
  // level) so leaving reset never manufactures a falling edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync     <= 2'b11;
      run_cnt  <= '0;
      filtered <= 1'b1;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == filtered) begin
        run_cnt <= '0;
      end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
        // This is the FILTER_LEN-th disagreeing sample in a row.
        filtered <= sync[1];
        run_cnt  <= '0;
      end else begin
        run_cnt <= run_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame
//   Deserialises 11-bit PS/2 device-to-host frames (start, D0..D7 LSB first,
//   odd parity, stop) into bytes for the keyboard scan-code FSM. Each good
//   byte appears on data_out for exactly one cycle with data_valid; data_out
//   is 8'h00 at all other times. Dropped frames pulse frame_err.
// Ports:
//   clk        in   system clock
//   resetn     in   asynchronous active-low reset
//   ps2_clk    in   raw PS/2 clock pad
//   ps2_data   in   raw PS/2 data pad
//   data_out   out  received byte while data_valid, else 8'h00
//   data_valid out  one-cycle pulse per accepted byte
//   frame_err  out  one-cycle pulse per dropped frame
//   busy       out  frame FSM is outside IDLE
// Configuration:
//   PS2_RX_PARITY_CHECK_EN - when defined, odd parity is part of the
//   acceptance test; otherwise the parity bit is clocked through and ignored.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic                       clk_filt;
  logic                       clk_filt_q;
  logic                       fall;
  logic [1:0]                 data_sync;
  logic                       bit_in;
  rx_state_t                  state;
  rx_state_t                  state_next;
  logic [2:0]                 bit_cnt;
  logic [FRAME_DATA_BITS-1:0] shift;
  logic [TW-1:0]              to_cnt;
  logic                       timeout;
  logic                       frame_ok;
  logic                       accept;
  logic                       reject;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk      (clk),
    .resetn   (resetn),
    .raw      (ps2_clk),
    .filtered (clk_filt)
  );

  // Data needs no filtering: it is only looked at on a filtered clock fall,
  // long after it has settled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_sync  <= 2'b11;
      clk_filt_q <= 1'b1;
    end else begin
      data_sync  <= {data_sync[0], ps2_data};
      clk_filt_q <= clk_filt;
    end
  end

  assign fall   = clk_filt_q & ~clk_filt;
  assign bit_in = data_sync[1];

  // Fires on the cycle the counter steps to TIMEOUT_CYCLES; a simultaneous
  // fall keeps the frame alive instead.
  assign timeout = (state != ST_IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

`ifdef PS2_RX_PARITY_CHECK_EN
  logic parity_bit;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      parity_bit <= 1'b0;
    end else if (state == ST_PARITY && fall) begin
      parity_bit <= bit_in;
    end
  end

  assign frame_ok = bit_in && odd_parity_ok(shift, parity_bit);
`else
  assign frame_ok = bit_in;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    reject     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // A fall with data high is a spurious start and is dropped silently.
        if (fall && !bit_in) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (fall && bit_cnt == 3'(FRAME_DATA_BITS - 1)) state_next = ST_PARITY;
      end
      ST_PARITY: begin
        if (fall) state_next = ST_STOP;
      end
      ST_STOP: begin
        if (fall) begin
          state_next = ST_IDLE;
          accept     = frame_ok;
          reject     = !frame_ok;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (timeout) begin
      state_next = ST_IDLE;
      reject     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      to_cnt     <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (state == ST_IDLE || fall) begin
        to_cnt <= '0;
      end else if (to_cnt != TW'(TIMEOUT_CYCLES)) begin
        to_cnt <= to_cnt + TW'(1);
      end

      if (state == ST_IDLE && fall && !bit_in) begin
        bit_cnt <= '0;
      end else if (state == ST_DATA && fall) begin
        // Wraps 7 -> 0 on the last data bit, ready for the next frame.
        bit_cnt <= bit_cnt + 3'd1;
        shift   <= {bit_in, shift[FRAME_DATA_BITS-1:1]};
      end

      data_valid <= accept;
      data_out   <= accept ? shift : 8'h00;
      frame_err  <= reject;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: doc/ps2_rx_frame.md
# ps2_rx_frame

Receives the raw PS/2 keyboard line pair (ps2_clk, ps2_data), synchronises and glitch-filters it, and deserialises 11-bit device-to-host frames into bytes. Sits directly upstream of the keyboard scan-code FSM and drives that FSM's 8-bit data input. Each good byte is presented for exactly one system clock, and 8'h00 is presented otherwise, so the downstream FSM sees each scan code (E0, F0, 75, ...) exactly once.

## Interface
- TIMEOUT_CYCLES, 50000: number of clk cycles without a ps2_clk falling edge, mid-frame, before the frame is aborted (1 ms at 50 MHz).
- FILTER_LEN, 4: number of consecutive equal synchronised samples required before the filtered ps2_clk changes level.
- clk  in  1  system clock; the only clock in the block.
- resetn  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock from the pad; asynchronous to clk.
- ps2_data  in  1  raw PS/2 data from the pad; asynchronous to clk.
- data_out  out  8  received byte while data_valid=1; 8'h00 at all other times.
- data_valid  out  1  one-cycle pulse for each accepted byte.
- frame_err  out  1  one-cycle pulse when a frame is dropped.
- busy  out  1  high while the FSM is outside IDLE.

## Operation
- **Input conditioning**
  - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
  - The synchronised ps2_clk feeds a filter. The filtered clock changes level only after FILTER_LEN consecutive identical samples. Its reset value is 1.
  - fall = previous filtered clock is 1 and current filtered clock is 0.
  - On each fall, the bit sampled is the synchronised ps2_data in the same cycle.
- **Frame format:** start (0), D0..D7 LSB first, odd parity, stop (1).
- **FSM states:** IDLE, DATA, PARITY, STOP. The state encoding lives in the package.
- **IDLE**
  - fall with bit=0 → DATA, bit counter cleared.
  - fall with bit=1 → stay in IDLE; this is a spurious start and is ignored silently (no frame_err).
- **DATA:** each fall shifts the bit into shift[7] and right-shifts the register. After the 8th bit → PARITY. The 3-bit counter wraps 7→0 on that transition.
- **PARITY:** on fall, the parity bit is stored → STOP.
- **STOP**, on fall:
  - bit=1 and parity OK → accept: data_valid=1 and data_out=shift in the next cycle.
  - Otherwise → frame_err=1 in the next cycle and the byte is discarded.
  - Always → IDLE.
- **Timeout**
  - The counter clears on every fall and when in IDLE, and increments otherwise. It saturates; width is $clog2(TIMEOUT_CYCLES+1).
  - Count reaching TIMEOUT_CYCLES outside IDLE → IDLE, plus a frame_err pulse the next cycle.
  - If a fall and the timeout occur in the same cycle, the fall wins and the counter clears.
- **Reset values:** data_out=8'h00, data_valid=0, frame_err=0, busy=0, state=IDLE, shift=0, counters=0, filtered clock=1, synchroniser flops=1.
- **Reset mid-frame:** the partial frame is lost, with no pulse. The block resynchronises on the next start bit after release.
- data_valid and frame_err are never high in the same cycle.

## Timing
- The filtered clock lags the pad by 2 + FILTER_LEN clk cycles.
- data_valid rises 1 cycle after the fall that samples the stop bit. It is high for exactly 1 cycle, and data_out returns to 8'h00 the following cycle.
- End-to-end, pad falling edge of the stop bit → data_valid takes 3 + FILTER_LEN cycles.
- Back-to-back frames need no idle gap. The next start bit may arrive on any fall after STOP.
- No backpressure: the consumer must accept every pulse. The downstream FSM samples every clk, which satisfies this.

## Configuration
- PS2_RX_PARITY_CHECK_EN
  - **Defined:** the stop-bit acceptance condition includes odd parity over D0..D7 plus the parity bit. A parity failure produces frame_err and drops the byte.
  - **Undefined:** the parity bit is still clocked through PARITY but is ignored. Only a bad stop bit or a timeout raises frame_err.

## Structure
- **ps2_pkg:** FSM state typedef, FRAME_DATA_BITS=8, and the scan-code constants SC_EXTENDED=8'hE0, SC_RELEASE=8'hF0, SC_UP=8'h75, SC_RIGHT=8'h74, SC_LEFT=8'h6B. These are shared with the downstream FSM.
- **Sub-module ps2_line_filter:** 2-FF synchroniser plus a FILTER_LEN run-length filter, with a registered output. Instantiated for ps2_clk; ps2_data uses the synchroniser only.
- The frame FSM, shift register and timeout counter live in ps2_rx_frame.

## Test plan
- **Single byte:** drive the frame for 8'h75 (start 0; bits 1,0,1,0,1,1,1,0; parity 0; stop 1) at ~12.5 kHz → one data_valid with data_out=8'h75, and data_out=8'h00 on every other cycle.
- **Release sequence:** frames E0, F0, 75 back-to-back → three pulses in order E0, F0, 75, and no frame_err.
- **Bad parity:** the 8'h74 frame with parity bit 0 → with the macro defined, frame_err pulses once and there is no data_valid; without it, data_valid with 8'h74.
- **Bad stop and timeout:** the 8'h6B frame with stop bit 0 → frame_err. Separately, stop clocking after 4 data bits → frame_err exactly TIMEOUT_CYCLES+1 cycles after the last fall, then busy=0.
- **Glitch and reset:** a 2-cycle low glitch on ps2_clk in IDLE → no state change. Assert resetn=0 after 5 data bits and release it → all outputs 0, and the next full 8'hE0 frame is received correctly.
